synapse_mux_integrator: RTL
===========================

// Module: synapse_mux_integrator
// PURPOSE
//   Upstream stage of the LIF neuron. Scans N_CH input spike channels, one per cycle,
//   and adds a signed per-channel weight for each spiking channel. Clamps the running sum
//   and publishes it once per frame as the unsigned synaptic current that drives lif.current.
// PARAMETERS
//   N_CH         8   number of input spike channels (>=2)
//   W_W          6   signed weight width (two's complement, -32..31 at default)
//   CUR_W        8   output current width (unsigned, matches lif.current)
//   DECAY_SHIFT  1   leak shift applied to previous current when SYN_LEAK_EN is defined
// PORTS
//   clk             in   1                 clock, rising edge
//   rst             in   1                 synchronous, active-high reset
//   spike_in        in   N_CH              raw input spikes, sampled every cycle
//   weight_wr_en    in   1                 weight write strobe
//   weight_wr_addr  in   $clog2(N_CH)      channel to write
//   weight_wr_data  in   W_W               signed weight value
//   current_out     out  CUR_W             registered synaptic current for lif
//   current_valid   out  1                 1-cycle pulse when current_out updates
//   busy            out  1                 high in SCAN and PUBLISH states
// BEHAVIOUR
//   Reset: current_out=0, current_valid=0, busy=0, all weights=0, pending=0, acc=0,
//     ch=0, state=LATCH. Reset at any point, including mid-SCAN, aborts the frame.
//     No partial sum is published.
//   FSM: LATCH -> SCAN (N_CH cycles) -> PUBLISH -> LATCH. Frame period = N_CH+2 cycles.
//   Sticky capture: every cycle, pending |= spike_in. No spike is lost between frames.
//   LATCH: spike_lat <= pending | spike_in; pending <= 0, except spikes arriving this cycle
//     go into spike_lat and not pending. acc <= seed (see CONFIGURATION). ch <= 0.
//   SCAN: at ch k (ascending 0..N_CH-1), if spike_lat[k] then acc += sext(weight[k]).
//     Clamp to [0, 2^CUR_W-1] after every add, so order matters.
//     acc is CUR_W+2 bits signed internally.
//   PUBLISH: current_out <= acc[CUR_W-1:0]; current_valid=1 in the following cycle only,
//     which coincides with the next LATCH.
//   First valid pulse: cycle N_CH+2 after reset deasserts (cycle 0 = first LATCH).
//   Weight write: accepted in any state, takes effect next cycle. A write to channel k in
//     the same cycle that k is scanned uses the OLD weight (read-before-write).
//   spike_in during SCAN/PUBLISH: counted in the next frame, never the current one.
// CONFIGURATION
//   SYN_LEAK_EN defined:
//     LATCH seed = current_out - (current_out >> DECAY_SHIFT), so charge carries over and decays.
//   SYN_LEAK_EN undefined:
//     LATCH seed = 0, giving a pure per-frame weighted sum. DECAY_SHIFT is unused.
// STRUCTURE
//   synapse_pkg: state enum {LATCH, SCAN, PUBLISH}; clamp function; width-derived localparams.
//   Sub-module syn_weight_rf: N_CH x W_W register file, 1 sync write port, 1 async read
//     port indexed by ch, resets to 0.
//   Top holds the FSM, channel counter, pending/spike_lat registers, accumulator and
//     output registers.
// TESTING (N_CH=8, W_W=6, CUR_W=8, DECAY_SHIFT=1)
//   1. Reset, no spikes:
//      current_out=0; current_valid pulses at cycles 10, 20, 30; busy high cycles 1-9 of each frame.
//   2. w0=20, w3=15, 1-cycle spikes on ch0, ch3 before frame:
//      next publish 35. Leak on: following spike-free frame gives 18. Leak off: it gives 0.
//   3. All weights 31, all channels spiking every frame:
//      leak off, 248 every frame. Leak on, 248 then clamped to 255.
//   4. Inhibition with w0=-32, w1=31, both spiking, leak off:
//      clamp after ch0 gives 0, then 31. current_out=31, not -1.
//   5. Spike on ch2 at mid-SCAN cycle 5, plus a write of w2 during the ch2 scan cycle:
//      the spike is absent from this publish and present in the next. The old w2 applies
//      this frame; the new w2 applies in the next.
//   6. rst asserted 1 cycle at SCAN cycle 4, with acc nonzero:
//      next cycle all outputs 0, weights 0, pending 0; next valid at 10 cycles after release.

Source files
------------

// File: rtl/synapse_pkg.sv
// synapse_pkg: shared FSM states, accumulator sizing and the current clamp for synapse_mux_integrator.
package synapse_pkg;
  typedef enum logic [1:0] {LATCH, SCAN, PUBLISH} state_t;
  localparam int ACC_XTRA = 2;
  function automatic int clamp_cur(input int v, input int hi);
    return v < 0 ? 0 : (v > hi ? hi : v);
  endfunction
endpackage

// File: rtl/syn_weight_rf.sv
// syn_weight_rf: per-channel signed weight register file, one sync write port and one async read port.
module syn_weight_rf #(
  parameter int N_CH = 8,
  parameter int W_W  = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [$clog2(N_CH)-1:0] wr_addr,
  input  logic [W_W-1:0]          wr_data,
  input  logic [$clog2(N_CH)-1:0] rd_addr,
  output logic [W_W-1:0]          rd_data
);
  logic [W_W-1:0] mem [N_CH];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/synapse_mux_integrator.sv
// synapse_mux_integrator: scans spike channels, sums clamped signed weights, publishes current once per frame.
// Define SYN_LEAK_EN to seed each frame with the decayed previous current instead of zero.
module synapse_mux_integrator
  import synapse_pkg::*;
#(
  parameter int N_CH        = 8,
  parameter int W_W         = 6,
  parameter int CUR_W       = 8,
  parameter int DECAY_SHIFT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         spike_in,
  input  logic                    weight_wr_en,
  input  logic [$clog2(N_CH)-1:0] weight_wr_addr,
  input  logic [W_W-1:0]          weight_wr_data,
  output logic [CUR_W-1:0]        current_out,
  output logic                    current_valid,
  output logic                    busy
);
  localparam int AW    = $clog2(N_CH);
  localparam int ACC_W = CUR_W + ACC_XTRA;
  state_t                    state, state_nx;
  logic [AW-1:0]             ch;
  logic [N_CH-1:0]           pending, spike_lat;
  logic signed [ACC_W-1:0]   acc, acc_nx, seed;
  logic signed [W_W-1:0]     w_rd;
  syn_weight_rf #(.N_CH(N_CH), .W_W(W_W)) u_rf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (weight_wr_en),
    .wr_addr (weight_wr_addr),
    .wr_data (weight_wr_data),
    .rd_addr (ch),
    .rd_data (w_rd)
  );
`ifdef SYN_LEAK_EN
  assign seed = ACC_W'({{ACC_XTRA{1'b0}}, current_out - (current_out >> DECAY_SHIFT)});
`else
  logic [31:0] unused_decay;
  assign unused_decay = 32'(DECAY_SHIFT);
  assign seed = '0;
`endif
  always_comb begin
    state_nx = state == LATCH ? SCAN :
               state == SCAN  ? (ch == AW'(N_CH - 1) ? PUBLISH : SCAN) : LATCH;
    acc_nx   = ACC_W'(clamp_cur(int'(acc) + int'(w_rd), (1 << CUR_W) - 1));
    busy     = state != LATCH;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= LATCH;
      ch            <= '0;
      pending       <= '0;
      spike_lat     <= '0;
      acc           <= '0;
      current_out   <= '0;
      current_valid <= 1'b0;
    end else begin
      state         <= state_nx;
      current_valid <= state == PUBLISH;
      // spikes seen during LATCH go straight into this frame, so pending only collects outside it
      pending       <= state == LATCH ? '0 : pending | spike_in;
      if (state == LATCH) begin
        spike_lat <= pending | spike_in;
        acc       <= seed;
        ch        <= '0;
      end
      if (state == SCAN) begin
        if (spike_lat[ch]) acc <= acc_nx;
        ch <= ch + AW'(1);
      end
      if (state == PUBLISH) current_out <= acc[CUR_W-1:0];
    end
  end
endmodule
